// File: rtl/inv_lut_pkg.sv
// Shared constants and helpers for the programmable per-lane lookup array.
// Default geometry is a 4-lane, 4-bit inverter with a 16-bit event counter.
package inv_lut_pkg;

  localparam int CH_DEF    = 4;
  localparam int W_DEF     = 4;
  localparam int CNT_W_DEF = 16;

  function automatic logic [31:0] default_entry(input logic [31:0] addr);
    return ~addr;
  endfunction

endpackage

// File: rtl/inv_lut_lane.sv
// One lane: a 2**W-entry programmable table with a registered lookup
// and unknown-input detection on the S1 data feeding it.
module inv_lut_lane
  import inv_lut_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic         we,
  input  logic [W-1:0] s1_data,
  input  logic [W-1:0] waddr,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] out_data,
  output logic         out_unk,
  output logic         unk_now
);

  localparam int D = 2 ** W;

  logic [W-1:0] tbl_q [D];
  logic [W-1:0] tbl_d [D];
  logic [W-1:0] data_q, data_d;
  logic         unk_q, unk_d;
  logic [W-1:0] look;

  always_comb begin
    tbl_d = tbl_q;
    if (we) tbl_d[waddr] = wdata;
  end

  // Lookup reads the pre-write table, so a same-edge write is seen next time.
  always_comb begin
    unk_now = $isunknown(s1_data);
    look    = unk_now ? {W{1'bx}} : tbl_q[s1_data];
    data_d  = data_q;
    unk_d   = unk_q;
    if (ld) begin
      data_d = look;
      unk_d  = unk_now;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < D; i++) begin
        tbl_q[i] <= W'(default_entry(i));
      end
      data_q <= '0;
      unk_q  <= 1'b0;
    end else begin
      tbl_q  <= tbl_d;
      data_q <= data_d;
      unk_q  <= unk_d;
    end
  end

  assign out_data = data_q;
  assign out_unk  = unk_q;

endmodule

// File: rtl/inv_lut_array.sv
// CH-lane programmable lookup with a two-stage valid/ready pipeline
// and a saturating count of transactions carrying unknown lanes.
module inv_lut_array
  import inv_lut_pkg::*;
#(
  parameter int CH    = CH_DEF,
  parameter int W     = W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [CH*W-1:0]                      in_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [CH*W-1:0]                      out_data,
  output logic [CH-1:0]                        out_unk,
  input  logic                                 cfg_we,
  input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0] cfg_ch,
  input  logic [W-1:0]                         cfg_addr,
  input  logic [W-1:0]                         cfg_data,
  output logic [CNT_W-1:0]                     unk_count
);

  logic              s1_valid_q, s1_valid_d;
  logic [CH*W-1:0]   s1_data_q, s1_data_d;
  logic              s2_valid_q, s2_valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              s1_adv, s2_adv, s2_ld;
  logic [CH-1:0]     unk_now;

  always_comb begin
    s2_adv     = !s2_valid_q || out_ready;
    s1_adv     = !s1_valid_q || s2_adv;
    s2_ld      = s2_adv && s1_valid_q;
    s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
    s1_valid_d = s1_adv ? in_valid : s1_valid_q;
    s1_data_d  = (s1_adv && in_valid) ? in_data : s1_data_q;
    cnt_d      = cnt_q;
    if (s2_ld && (|unk_now) && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s2_valid_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s2_valid_q <= s2_valid_d;
      cnt_q      <= cnt_d;
    end
  end

  assign in_ready  = s1_adv;
  assign out_valid = s2_valid_q;
  assign unk_count = cnt_q;

  // Out-of-range lane numbers match no lane and are dropped.
  for (genvar k = 0; k < CH; k++) begin : g_lane
    logic lane_we;
    assign lane_we = cfg_we && (32'(cfg_ch) == k);

    inv_lut_lane #(.W(W)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .ld       (s2_ld),
      .we       (lane_we),
      .s1_data  (s1_data_q[k*W +: W]),
      .waddr    (cfg_addr),
      .wdata    (cfg_data),
      .out_data (out_data[k*W +: W]),
      .out_unk  (out_unk[k]),
      .unk_now  (unk_now[k])
    );
  end

endmodule

// File: doc/inv_lut_array.md
INV_LUT_ARRAY -- requirements
Module: inv_lut_array

Interface
REQ-001 SHALL have parameter CH, default 4, meaning number of independent inverter lanes.
REQ-002 SHALL have parameter W, default 4, meaning bits per lane; table depth is 2**W.
REQ-003 SHALL have parameter CNT_W, default 16, meaning the unknown-event counter width.
REQ-004 SHALL have port clk  input  1  meaning the single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst  input  1  meaning reset, synchronous and active-high.
REQ-006 SHALL have port in_valid  input  1  meaning the input transaction is valid.
REQ-007 SHALL have port in_ready  output  1  meaning the block accepts input this cycle.
REQ-008 SHALL have port in_data  input  CH*W  meaning lane k occupies bits [k*W +: W].
REQ-009 SHALL have port out_valid  output  1  meaning the output transaction is valid.
REQ-010 SHALL have port out_ready  input  1  meaning downstream accepts output this cycle.
REQ-011 SHALL have port out_data  output  CH*W  meaning the per-lane lookup result.
REQ-012 SHALL have port out_unk  output  CH  meaning lane k had an unknown (X/Z) input.
REQ-013 SHALL have port cfg_we  input  1  meaning a table write strobe.
REQ-014 SHALL have port cfg_ch  input  $clog2(CH) (min 1)  meaning the lane to write.
REQ-015 SHALL have port cfg_addr  input  W  meaning the table entry index.
REQ-016 SHALL have port cfg_data  input  W  meaning the new entry value.
REQ-017 SHALL have port unk_count  output  CNT_W  meaning transactions with any unknown lane, saturating.

Function
REQ-018 SHALL hold one table per lane, 2**W entries of W bits, each entry a resettable register.
REQ-019 SHALL hold default entry value ~addr (bitwise inversion) after reset, so the unprogrammed block is a CH-lane W-bit inverter.
REQ-020 SHALL implement a two-stage pipeline: S1 registers in_data; S2 registers the table lookup; latency is exactly 2 cycles from an accepted input to out_valid.
REQ-021 SHALL accept input on a cycle when in_valid && in_ready, and transfer output on a cycle when out_valid && out_ready.
REQ-022 SHALL advance S2 when !s2_valid || out_ready, advance S1 when !s1_valid || S2 advances, and drive in_ready = S1 advancing; throughput is one transaction per cycle when out_ready stays high.
REQ-023 SHALL hold out_data, out_unk and out_valid stable while out_valid && !out_ready; no transaction is dropped or duplicated.
REQ-024 SHALL ignore cfg_ch >= CH (no write); a write updates the table on the clock edge and affects lookups performed from the next cycle onward.
REQ-025 SHALL use the old entry value when a cfg write and an S2 lookup of the same lane/entry occur in the same cycle.
REQ-026 SHALL drive out_data lane all-X and set out_unk[k] when lane k's S1 data contains any X/Z bit (simulation behaviour; the detection evaluates to 0 in synthesis).
REQ-027 SHALL increment unk_count by 1 per transaction entering S2 with any out_unk bit set, and hold it at 2**CNT_W-1 once saturated.
REQ-028 SHALL make in_ready, out_valid and the lookup path independent of cfg_we; configuration never stalls data.

Reset
REQ-029 SHALL, on rst high at a clock edge, clear s1_valid/s2_valid (out_valid=0), drive out_data=0, out_unk=0, unk_count=0 and restore all table entries to ~addr.
REQ-030 SHALL discard in-flight transactions when reset occurs mid-operation; in_ready is 1 in the first cycle after reset deasserts.
REQ-031 SHALL give rst priority over a simultaneous cfg_we or input handshake.

Structure
REQ-032 SHALL place default CH/W/CNT_W constants and a default_entry(addr) function in package inv_lut_pkg.
REQ-033 SHALL use one sub-module, inv_lut_lane (one table, write decode, registered lookup, unknown detect), instantiated CH times; handshake and counter logic stay in the top level.

Verification
REQ-034 SHALL cover: after reset, in_data=16'h3210 held valid, out_ready=1 -> out_data=16'hCDEF two cycles later, out_unk=0.
REQ-035 SHALL cover: cfg write lane 2, addr 4'h5, data 4'h5, then in_data=16'h0500 -> out_data=16'hF5FF.
REQ-036 SHALL cover: 8 back-to-back inputs with out_ready low for cycles 3-5 -> all 8 outputs appear in order, unchanged while stalled, in_ready drops once both stages are full.
REQ-037 SHALL cover: lane 1 input 4'bx -> out_data lane 1 = 4'bxxxx, out_unk=4'b0010, unk_count=1; CNT_W=2 with 5 such inputs -> unk_count=3.
REQ-038 SHALL cover: rst asserted with 2 transactions in flight and table reprogrammed -> out_valid=0 next cycle, table back to ~addr, no stale outputs.
REQ-039 SHALL cover: same-cycle cfg write and lookup of that entry -> old value output, new value on the following transaction.
